branch_target_buffer: RTL and testbench

//  Prediction table that supplies the branch unit with a PC match, predicted target and 2-bit

---
 rtl/branch_target_buffer_pkg.sv | 35 +++
 rtl/btb_entry_array.sv | 69 ++++++
 rtl/branch_target_buffer.sv | 144 ++++++++++++++
 tb/tb_branch_target_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared branch-prediction definitions: counter encodings, NPC select codes,
// default BTB geometry and the tag/index split helpers.
package branch_target_buffer_pkg;

  localparam int BTB_AW      = 32;
  localparam int BTB_ENTRIES = 16;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctrl_e;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'b00,
    NPC_PRED = 2'b01,
    NPC_RES  = 2'b10,
    NPC_EXC  = 2'b11
  } npc_sel_e;

  typedef enum logic {
    BTB_IDLE  = 1'b0,
    BTB_SWEEP = 1'b1
  } btb_state_e;

  function automatic int btb_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int btb_tag_w(input int aw, input int entries);
    return aw - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/btb_entry_array.sv
// BTB entry storage: valid vector, tag/target/ctrl arrays,
// single-entry sweep clear and write-first read path.
module btb_entry_array
  import branch_target_buffer_pkg::*;
#(
  parameter int AW      = BTB_AW,
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = btb_idx_w(ENTRIES),
  parameter int TAG_W   = btb_tag_w(AW, ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [AW-1:0]    wr_target,
  input  logic [1:0]       wr_ctrl,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  output logic             rd_hit,
  output logic [AW-1:0]    rd_target,
  output logic [1:0]       rd_ctrl
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [AW-1:0]      target_q [ENTRIES];
  logic [1:0]         ctrl_q   [ENTRIES];

  logic             fwd;
  logic             e_valid;
  logic [TAG_W-1:0] e_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (wr_en) valid_q[wr_idx] <= 1'b1;
      if (clr_en) valid_q[clr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctrl_q[wr_idx]   <= wr_ctrl;
    end
  end

  // A write landing this edge is visible to the lookup made in the same cycle.
  always_comb begin
    fwd       = wr_en && (wr_idx == rd_idx);
    e_valid   = valid_q[rd_idx];
    e_tag     = tag_q[rd_idx];
    rd_target = target_q[rd_idx];
    rd_ctrl   = ctrl_q[rd_idx];
    if (fwd) begin
      e_valid   = 1'b1;
      e_tag     = wr_tag;
      rd_target = wr_target;
      rd_ctrl   = wr_ctrl;
    end
    rd_hit = e_valid && (e_tag == rd_tag);
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged BTB: invalidate-sweep FSM, registered lookup response.
// Optional hit/miss counters are built when BTB_PERF_CNT_EN is defined.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int AW      = BTB_AW,
  parameter int ENTRIES = BTB_ENTRIES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lookup_valid,
  input  logic [AW-1:0] lookup_pc,
  output logic          resp_valid,
  output logic          pc_match_valid,
  output logic [AW-1:0] pred_target,
  output logic [1:0]    pred_ctrl,
  output logic          pred_taken,
  input  logic          upd_en,
  input  logic [AW-1:0] upd_pc,
  input  logic [AW-1:0] upd_target,
  input  logic [1:0]    upd_ctrl,
  input  logic          inv_all,
  output logic          busy
`ifdef BTB_PERF_CNT_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int IDX_W = btb_idx_w(ENTRIES);
  localparam int TAG_W = btb_tag_w(AW, ENTRIES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  btb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             clr_en;

  logic             wr_en;
  logic             rd_hit;
  logic [AW-1:0]    rd_target;
  logic [1:0]       rd_ctrl;
  logic             hit;

  logic             resp_q;
  logic             hit_q;
  logic [AW-1:0]    target_q;
  logic [1:0]       ctrl_q;

  assign busy  = (state_q == BTB_SWEEP);
  assign wr_en = upd_en && !busy;
  assign hit   = rd_hit && !busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BTB_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    unique case (state_q)
      BTB_IDLE: begin
        if (inv_all) begin
          state_d = BTB_SWEEP;
          ptr_d   = '0;
        end
      end
      BTB_SWEEP: begin
        clr_en = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = BTB_IDLE;
      end
      default: state_d = BTB_IDLE;
    endcase
  end

  btb_entry_array #(
    .AW      (AW),
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (lookup_pc[IDX_W+1:2]),
    .rd_tag    (lookup_pc[AW-1:IDX_W+2]),
    .wr_en     (wr_en),
    .wr_idx    (upd_pc[IDX_W+1:2]),
    .wr_tag    (upd_pc[AW-1:IDX_W+2]),
    .wr_target (upd_target),
    .wr_ctrl   (upd_ctrl),
    .clr_en    (clr_en),
    .clr_idx   (ptr_q),
    .rd_hit    (rd_hit),
    .rd_target (rd_target),
    .rd_ctrl   (rd_ctrl)
  );

  // Prediction fields hold between lookups; only the valid flags track resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q   <= 1'b0;
      hit_q    <= 1'b0;
      target_q <= '0;
      ctrl_q   <= BP_SNT;
    end else begin
      resp_q <= lookup_valid;
      if (lookup_valid) begin
        hit_q    <= hit;
        target_q <= hit ? rd_target : '0;
        ctrl_q   <= hit ? rd_ctrl : BP_SNT;
      end
    end
  end

  assign resp_valid     = resp_q;
  assign pc_match_valid = resp_q && hit_q;
  assign pred_target    = target_q;
  assign pred_ctrl      = ctrl_q;
  assign pred_taken     = pc_match_valid && ctrl_q[1];

`ifdef BTB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_q) begin
      if (hit_q) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (ENTRIES=16, AW=32).
// Inputs change just after a rising edge; outputs are checked #1 after it.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        resp_valid;
  logic        pc_match_valid;
  logic [31:0] pred_target;
  logic [1:0]  pred_ctrl;
  logic        pred_taken;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [1:0]  upd_ctrl;
  logic        inv_all;
  logic        busy;
`ifdef BTB_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int bcount;

  always #5 clk = ~clk;

  branch_target_buffer #(.AW(32), .ENTRIES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .resp_valid     (resp_valid),
    .pc_match_valid (pc_match_valid),
    .pred_target    (pred_target),
    .pred_ctrl      (pred_ctrl),
    .pred_taken     (pred_taken),
    .upd_en         (upd_en),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_ctrl       (upd_ctrl),
    .inv_all        (inv_all),
    .busy           (busy)
`ifdef BTB_PERF_CNT_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    lookup_valid = 1'b0;
    upd_en       = 1'b0;
    inv_all      = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic [1:0] c);
    upd_en = 1'b1; upd_pc = pc; upd_target = tgt; upd_ctrl = c;
    tick();
    upd_en = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_valid = 1'b1; lookup_pc = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic m,
                          input logic [31:0] tgt, input logic [1:0] c);
    chk({tag, "_rv"}, 32'(resp_valid), 32'd1);
    chk({tag, "_hit"}, 32'(pc_match_valid), 32'(m));
    chk({tag, "_tgt"}, pred_target, tgt);
    chk({tag, "_ctrl"}, 32'(pred_ctrl), 32'(c));
    chk({tag, "_tkn"}, 32'(pred_taken), 32'(m & c[1]));
  endtask

  initial begin
    rst = 1'b1;
    lookup_pc = '0; upd_pc = '0; upd_target = '0; upd_ctrl = '0;
    idle_in();
    tick(); tick();
    rst = 1'b0;

    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_hit", 32'(pc_match_valid), 32'd0);
    chk("rst_tgt", pred_target, 32'd0);
    chk("rst_ctrl", 32'(pred_ctrl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    look(32'h40);
    chk_resp("t1", 1'b0, 32'h0, 2'b00);

    upd(32'h40, 32'h100, 2'b10);
    look(32'h40);
    chk_resp("t2", 1'b1, 32'h100, 2'b10);

    upd_en = 1'b1; upd_pc = 32'h80; upd_target = 32'h200; upd_ctrl = 2'b01;
    lookup_valid = 1'b1; lookup_pc = 32'h80;
    tick();
    idle_in();
    chk_resp("t3", 1'b1, 32'h200, 2'b01);
    tick();
    chk("hold_rv", 32'(resp_valid), 32'd0);
    chk("hold_hit", 32'(pc_match_valid), 32'd0);
    chk("hold_tgt", pred_target, 32'h200);

    upd(32'h40, 32'h100, 2'b10);
    look(32'h80);
    chk_resp("t4_old", 1'b0, 32'h0, 2'b00);
    upd(32'h440, 32'h300, 2'b11);
    look(32'h40);
    chk_resp("t4_alias", 1'b0, 32'h0, 2'b00);
    look(32'h440);
    chk_resp("t4_new", 1'b1, 32'h300, 2'b11);

    upd(32'h04, 32'h1004, 2'b11);
    upd(32'h08, 32'h1008, 2'b00);
    upd(32'h0C, 32'h100C, 2'b10);
    upd(32'h3C, 32'h103C, 2'b01);
    look(32'h3C);
    chk_resp("t5_pre", 1'b1, 32'h103C, 2'b01);

    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    bcount = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy) bcount++;
      if (i == 4) begin
        chk("t5_mid_busy", 32'(busy), 32'd1);
        chk("t5_mid_rv", 32'(resp_valid), 32'd1);
        chk("t5_mid_hit", 32'(pc_match_valid), 32'd0);
      end
      if (i == 3) begin
        upd_en = 1'b1; upd_pc = 32'h10; upd_target = 32'h1010; upd_ctrl = 2'b11;
        lookup_valid = 1'b1; lookup_pc = 32'h3C;
      end else begin
        idle_in();
      end
      tick();
    end
    idle_in();
    chk("t5_busy_cycles", 32'(bcount), 32'd16);
    chk("t5_busy_end", 32'(busy), 32'd0);
    look(32'h04);
    chk_resp("t5_a", 1'b0, 32'h0, 2'b00);
    look(32'h0C);
    chk_resp("t5_b", 1'b0, 32'h0, 2'b00);
    look(32'h3C);
    chk_resp("t5_c", 1'b0, 32'h0, 2'b00);
    look(32'h440);
    chk_resp("t5_d", 1'b0, 32'h0, 2'b00);
    look(32'h10);
    chk_resp("t5_drop", 1'b0, 32'h0, 2'b00);

    upd(32'h04, 32'h2004, 2'b11);
    upd(32'h3C, 32'h203C, 2'b11);
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_busy_c5", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rv", 32'(resp_valid), 32'd0);
`ifdef BTB_PERF_CNT_EN
    chk("t6_hitcnt", hit_count, 32'd0);
    chk("t6_misscnt", miss_count, 32'd0);
`endif
    look(32'h04);
    chk_resp("t6_a", 1'b0, 32'h0, 2'b00);
    look(32'h3C);
    chk_resp("t6_b", 1'b0, 32'h0, 2'b00);
    tick();
    chk("t6_idle", 32'(busy), 32'd0);
`ifdef BTB_PERF_CNT_EN
    chk("t6_hitcnt2", hit_count, 32'd0);
    chk("t6_misscnt2", miss_count, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
